// File: rtl/hif_fir_mac.sv
// hif_fir_mac: burst FIR multiply-accumulate fed by the high-frequency sample queue and a synchronous coefficient ROM
module hif_fir_mac #(
    parameter int NUM_TAPS = 1021,
    parameter int ACC_W    = 42
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sequencing,
    input  logic signed [15:0] smpl_in,
    output logic [9:0]         coeff_addr,
    input  logic signed [15:0] coeff,
    output logic signed [15:0] filt_out,
    output logic               filt_vld,
    output logic               burst_err,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, OUT, WAIT_LOW} state_t;

    state_t                    state_q, state_d;
    logic [9:0]                tap_cnt_q, tap_cnt_d;
    logic                      drain_cnt_q, drain_cnt_d;
    logic signed [15:0]        smpl_q, smpl_d;
    logic signed [31:0]        prod_q, prod_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [15:0]        filt_out_q, filt_out_d;
    logic                      filt_vld_q, filt_vld_d;
    logic                      burst_err_q, burst_err_d;
    logic                      accept, clear, last, pos_ovf, neg_ovf;
    logic signed [ACC_W-1:0]   acc_sh;
    logic signed [15:0]        sat;

    assign last    = tap_cnt_q == 10'(NUM_TAPS - 1);
    assign acc_sh  = acc_q >>> 15;
    // acc_sh's top 15 bits are sign copies, so any disagreement below them is overflow
    assign pos_ovf = !acc_sh[ACC_W-1] && |acc_sh[ACC_W-2:15];
    assign neg_ovf = acc_sh[ACC_W-1] && !(&acc_sh[ACC_W-2:15]);
    assign sat     = pos_ovf ? 16'sh7FFF : neg_ovf ? 16'sh8000 : acc_sh[15:0];

    always_comb begin
        state_d     = state_q;
        tap_cnt_d   = '0;
        drain_cnt_d = 1'b0;
        accept      = 1'b0;
        clear       = 1'b0;
        burst_err_d = 1'b0;
        filt_vld_d  = 1'b0;
        filt_out_d  = filt_out_q;
        unique case (state_q)
            IDLE: if (sequencing) begin
                accept    = 1'b1;
                clear     = 1'b1;
                state_d   = last ? DRAIN : ACCUM;
                tap_cnt_d = last ? '0 : tap_cnt_q + 10'd1;
            end
            ACCUM: if (sequencing) begin
                accept    = 1'b1;
                state_d   = last ? DRAIN : ACCUM;
                tap_cnt_d = last ? '0 : tap_cnt_q + 10'd1;
            end else begin
                state_d     = IDLE;
                burst_err_d = 1'b1;
            end
            DRAIN: begin
                drain_cnt_d = !drain_cnt_q;
                state_d     = drain_cnt_q ? OUT : DRAIN;
            end
            OUT: begin
                filt_vld_d = 1'b1;
                filt_out_d = sat;
                state_d    = sequencing ? WAIT_LOW : IDLE;
            end
            WAIT_LOW: state_d = sequencing ? WAIT_LOW : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Unaccepted cycles inject zero samples so the accumulator can add every cycle
    assign smpl_d = accept ? smpl_in : 16'sd0;
    assign prod_d = smpl_q * coeff;
    assign acc_d  = clear ? '0 : acc_q + {{(ACC_W-32){prod_q[31]}}, prod_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tap_cnt_q   <= '0;
            drain_cnt_q <= 1'b0;
            smpl_q      <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            filt_out_q  <= '0;
            filt_vld_q  <= 1'b0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_cnt_q   <= tap_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            smpl_q      <= smpl_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            filt_out_q  <= filt_out_d;
            filt_vld_q  <= filt_vld_d;
            burst_err_q <= burst_err_d;
        end
    end

    assign coeff_addr = tap_cnt_q;
    assign filt_out   = filt_out_q;
    assign filt_vld   = filt_vld_q;
    assign burst_err  = burst_err_q;
    assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_hif_fir_mac.sv
// tb_hif_fir_mac: table-driven and randomized bursts against a dot-product reference model
module tb_hif_fir_mac;
    localparam int N = 1021;

    logic clk = 1'b0, rst = 1'b1, sequencing = 1'b0;
    logic signed [15:0] smpl_in = '0, coeff = '0, filt_out;
    logic [9:0] coeff_addr;
    logic filt_vld, burst_err, busy;

    int checks = 0, errors = 0;
    int vld_cnt, vld_at, err_cnt, err_at, addr_bad, busy_mid;
    logic signed [15:0] samp [N];
    logic signed [15:0] coef [1024];

    typedef struct {
        string name;
        logic signed [15:0] s;
        logic signed [15:0] c;
        int imp;
        int exp;
    } vec_t;
    vec_t tbl [4];

    hif_fir_mac #(.NUM_TAPS(N), .ACC_W(42)) dut (
        .clk(clk), .rst(rst), .sequencing(sequencing), .smpl_in(smpl_in),
        .coeff_addr(coeff_addr), .coeff(coeff), .filt_out(filt_out),
        .filt_vld(filt_vld), .burst_err(burst_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // synchronous coefficient ROM
    always @(posedge clk) coeff <= coef[coeff_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int golden();
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(samp[i]) * longint'(coef[i]);
        s = s >>> 15;
        return s > 32767 ? 32767 : s < -32768 ? -32768 : int'(s);
    endfunction

    function automatic void fill_random(int sh);
        for (int i = 0; i < N; i++) begin
            samp[i] = $signed(16'($urandom)) >>> sh;
            coef[i] = $signed(16'($urandom));
        end
    endfunction

    // period p: outputs observed then inputs driven, both 1 time unit after edge p
    task automatic burst(int n_high, int rj_s, int rj_len, int rst_at);
        int total = ((n_high > rj_s + rj_len) ? n_high : rj_s + rj_len) + 12;
        vld_cnt = 0; err_cnt = 0; vld_at = -1; err_at = -1; addr_bad = 0; busy_mid = -1;
        for (int p = 0; p < total; p++) begin
            if (filt_vld) begin vld_cnt++; vld_at = p; end
            if (burst_err) begin err_cnt++; err_at = p; end
            if (p < n_high && p < N && (rst_at < 0 || p <= rst_at) && coeff_addr != 10'(p)) addr_bad++;
            if (rj_len > 0 && p == rj_s + rj_len - 1) busy_mid = int'(busy);
            rst = (p == rst_at);
            sequencing = (p < n_high || (p >= rj_s && p < rj_s + rj_len)) && !(rst_at >= 0 && p >= rst_at);
            smpl_in = p < N ? samp[p] : 16'($urandom);
            step();
        end
        sequencing = 1'b0;
        rst = 1'b0;
    endtask

    task automatic good_burst(string tag, int exp);
        burst(N, 0, 0, -1);
        chk({tag, "_vld_cnt"}, vld_cnt, 1);
        chk({tag, "_vld_at"}, vld_at, 1024);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_addr"}, addr_bad, 0);
        chk({tag, "_out"}, filt_out, exp);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int prior, exp;
        for (int i = 0; i < 1024; i++) coef[i] = '0;
        repeat (3) step();
        chk("rst_out", filt_out, 0);
        chk("rst_vld", filt_vld, 0);
        chk("rst_err", burst_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", coeff_addr, 0);
        rst = 1'b0;
        repeat (3) step();
        chk("idle_busy", busy, 0);

        tbl[0] = '{"dc", 16'sh0010, 16'sh0100, -1, 127};
        tbl[1] = '{"impulse", 16'sh7FFF, 16'sh1234, 5, 4659};
        tbl[2] = '{"neg_sat", 16'sh8000, 16'sh7FFF, -1, -32768};
        tbl[3] = '{"pos_sat", 16'sh7FFF, 16'sh7FFF, -1, 32767};
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                samp[i] = (tbl[t].imp < 0 || i == tbl[t].imp) ? tbl[t].s : 16'sd0;
                coef[i] = (tbl[t].imp < 0 || i == tbl[t].imp) ? tbl[t].c : $signed(16'($urandom));
            end
            good_burst(tbl[t].name, tbl[t].exp);
        end

        for (int r = 0; r < 3; r++) begin
            fill_random(3 + r);
            good_burst("random", golden());
        end

        prior = int'(filt_out);
        fill_random(4);
        burst(500, 0, 0, -1);
        chk("abort_err_cnt", err_cnt, 1);
        chk("abort_err_at", err_at, 501);
        chk("abort_vld", vld_cnt, 0);
        chk("abort_out_hold", filt_out, prior);
        chk("abort_busy", busy, 0);
        fill_random(5);
        good_burst("after_abort", golden());

        fill_random(4);
        exp = golden();
        burst(1100, 0, 0, -1);
        chk("long_vld_cnt", vld_cnt, 1);
        chk("long_vld_at", vld_at, 1024);
        chk("long_err", err_cnt, 0);
        chk("long_out", filt_out, exp);
        chk("long_busy", busy, 0);
        fill_random(5);
        good_burst("after_long", golden());

        fill_random(4);
        exp = golden();
        burst(N, 1023, 8, -1);
        chk("rejoin_vld_cnt", vld_cnt, 1);
        chk("rejoin_vld_at", vld_at, 1024);
        chk("rejoin_err", err_cnt, 0);
        chk("rejoin_wait_busy", busy_mid, 1);
        chk("rejoin_out", filt_out, exp);
        chk("rejoin_busy", busy, 0);

        fill_random(3);
        burst(N, 0, 0, 700);
        chk("rstmid_vld", vld_cnt, 0);
        chk("rstmid_err", err_cnt, 0);
        chk("rstmid_out", filt_out, 0);
        chk("rstmid_busy", busy, 0);
        fill_random(4);
        good_burst("after_rst", golden());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
